alu_operand_sequencer: RTL and testbench
========================================

# alu_operand_sequencer

Front-end stage that sits directly upstream of the ALU on the DE10-Lite board. It walks the user through loading operand A, operand B and the 3-bit operation from the slide switches, one debounced Enter press per step. It drives the ALU's SrcA, SrcB and ALUControl inputs from registers, then captures the ALU's ALUResult and Zero outputs into held display registers.

## Interface
- WIDTH, 4: operand and result width; must match the ALU's WIDTH.
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required before a key level is accepted (10 ms at 50 MHz). Minimum 2.
- clk  in  1: board clock; all state updates on the rising edge.
- reset  in  1: asynchronous, active-high; clears all state immediately.
- Sw  in  WIDTH: operand value from the slide switches.
- OpSw  in  3: operation code from the slide switches.
- Enter  in  1: raw Enter key, active-high (board inversion is done outside this block), asynchronous to clk.
- Abort  in  1: raw Abort key, active-high, asynchronous to clk.
- ALUResult  in  WIDTH: ALU result.
- Zero  in  1: ALU zero flag.
- SrcA  out  WIDTH: registered operand A to the ALU.
- SrcB  out  WIDTH: registered operand B to the ALU.
- ALUControl  out  3: registered operation to the ALU.
- Result  out  WIDTH: captured ALU result, held for display.
- ZeroFlag  out  1: captured Zero flag.
- Valid  out  1: high while Result and ZeroFlag hold the result of the current operands.
- Done  out  1: single-cycle pulse on the cycle the result is captured.
- StateOut  out  3: current state encoding, for LEDs.

## Operation
- Enter and Abort each pass through a 2-flop synchronizer, then an optional debouncer, then a rising-edge detector. The edge detector compares the accepted level with its previous value.
- States and encodings: GET_A=0, GET_B=1, GET_OP=2, EXEC=3, SHOW=4. Encodings 5–7 are illegal and go to GET_A on the next edge.
- GET_A, on an Enter edge: SrcA<=Sw, Valid<=0, go to GET_B.
- GET_B, on an Enter edge: SrcB<=Sw, go to GET_OP.
- GET_OP, on an Enter edge: ALUControl<=OpSw, go to EXEC. The operation is always loaded last, so ALUControl is the final ALU input to change.
- EXEC lasts exactly one cycle and ignores Enter. It does Result<=ALUResult, ZeroFlag<=Zero, Valid<=1, Done<=1, then goes to SHOW.
- SHOW, on an Enter edge: go to GET_A. Result, ZeroFlag and Valid stay held until the next GET_A Enter edge.
- Abort edge, in any state: go to GET_A and clear Valid. SrcA, SrcB, ALUControl and Result keep their values.
- Abort and Enter edges in the same cycle: Abort wins and the Enter edge is discarded.
- A key held high yields exactly one edge. The next edge requires a release to be accepted first.
- Reset values: SrcA=0, SrcB=0, ALUControl=3'b000, Result=0, ZeroFlag=0, Valid=0, Done=0, StateOut=0 (GET_A). The synchronizer, debounce counters and previous-level registers are also cleared to 0.
- Reset asserted mid-operation (including EXEC): all outputs take their reset values at once. No capture completes.

## Timing
- Synchronizer: a raw key level reaches sync2 two edges after it is first sampled.
- Debounce on: the accepted level updates on the edge where sync2 has differed from it for DEBOUNCE_CYCLES consecutive edges. The counter resets to 0 whenever sync2 equals the accepted level.
- Debounce off: the accepted level equals sync2.
- State update happens on the edge after the accepted level rises. Latency from first raw sample to state change is 3 edges with debounce off, and 2+DEBOUNCE_CYCLES+1 edges with debounce on.
- EXEC to SHOW: Result and Done are visible 1 cycle after entering EXEC. Done is deasserted on the following edge.
- Debounce counters are ceil(log2(DEBOUNCE_CYCLES+1)) bits and saturate; they never wrap.

## Configuration
- ALU_SEQ_DEBOUNCE_EN defined: debounce counters are instantiated for Enter and Abort as described above.
- ALU_SEQ_DEBOUNCE_EN undefined: no counters are built, DEBOUNCE_CYCLES is ignored, and every synchronized rising edge counts as a press.

## Test plan
All scenarios use WIDTH=4, DEBOUNCE_CYCLES=4 and ALU_SEQ_DEBOUNCE_EN defined, unless noted.
- Reset: pulse reset asynchronously between clock edges -> all outputs 0 immediately, StateOut=0.
- Normal subtraction: Sw=4'h5 + Enter, Sw=4'h3 + Enter, OpSw=3'b001 + Enter -> SrcA=5, SrcB=3, ALUControl=001. One cycle in EXEC, then Result=4'h2, ZeroFlag=0, Valid=1, one-cycle Done, StateOut=4.
- Zero flag: A=7, B=7, op=001 -> Result=0, ZeroFlag=1. Then Enter in SHOW -> StateOut=0 and Valid stays 1 until the next Enter in GET_A.
- Bounce rejection: Enter high for 3 cycles, low for 1, high for 3 -> no state change. Enter then held for 10 cycles -> exactly one advance. With the macro undefined, the same glitch pattern -> two advances.
- Abort priority: in GET_B, Abort and Enter rise together -> StateOut=0, SrcB unchanged, Valid=0.
- Reset mid-operation: assert reset during the EXEC cycle -> Done never pulses and Result=0.

Source files
------------

// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer: steps the user through loading operand A, operand B
// and the ALU operation from the slide switches, one Enter press per step,
// then captures the ALU result and zero flag for display.
// Enter and Abort each pass through a 2-flop synchronizer, an optional
// debouncer and a rising-edge detector.
// Define ALU_SEQ_DEBOUNCE_EN to build the debounce counters. Without it,
// DEBOUNCE_CYCLES is ignored and every synchronized rising edge is a press.
module alu_operand_sequencer #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] Sw,
  input  logic [2:0]       OpSw,
  input  logic             Enter,
  input  logic             Abort,
  input  logic [WIDTH-1:0] ALUResult,
  input  logic             Zero,
  output logic [WIDTH-1:0] SrcA,
  output logic [WIDTH-1:0] SrcB,
  output logic [2:0]       ALUControl,
  output logic [WIDTH-1:0] Result,
  output logic             ZeroFlag,
  output logic             Valid,
  output logic             Done,
  output logic [2:0]       StateOut
);

  typedef enum logic [2:0] {
    GET_A  = 3'd0,
    GET_B  = 3'd1,
    GET_OP = 3'd2,
    EXEC   = 3'd3,
    SHOW   = 3'd4
  } state_e;

  // Key lanes: bit 0 is Enter, bit 1 is Abort.
  logic [1:0] raw_s;
  logic [1:0] sync1_q, sync1_d;
  logic [1:0] sync2_q, sync2_d;
  logic [1:0] prev_q, prev_d;
  logic [1:0] lvl_s;
  logic [1:0] edge_s;
  logic       enter_edge_s;
  logic       abort_edge_s;

  assign raw_s = {Abort, Enter};

  // Next values of the synchronizer stages and the previous accepted level.
  always_comb begin
    sync1_d = raw_s;
    sync2_d = sync1_q;
    prev_d  = lvl_s;
  end

  // Synchronizer and edge-detector history registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
      prev_q  <= 2'b00;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

`ifdef ALU_SEQ_DEBOUNCE_EN
  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);

  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];
  logic [1:0]       acc_q, acc_d;

  // Accept sync2 once it has differed from the accepted level for
  // DEBOUNCE_CYCLES consecutive edges; any agreement restarts the count.
  always_comb begin
    acc_d = acc_q;
    for (int k = 0; k < 2; k++) begin
      cnt_d[k] = cnt_q[k];
      if (sync2_q[k] == acc_q[k]) begin
        cnt_d[k] = {CNT_W{1'b0}};
      end else if (cnt_q[k] == CNT_LAST) begin
        acc_d[k] = sync2_q[k];
        cnt_d[k] = {CNT_W{1'b0}};
      end else if (cnt_q[k] < CNT_MAX) begin
        cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end else begin
        cnt_d[k] = cnt_q[k];
      end
    end
  end

  // Debounce counters and accepted levels.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= 2'b00;
      for (int k = 0; k < 2; k++) begin
        cnt_q[k] <= {CNT_W{1'b0}};
      end
    end else begin
      acc_q <= acc_d;
      for (int k = 0; k < 2; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  assign lvl_s = acc_q;
`else
  logic [31:0] unused_cfg_s;
  assign unused_cfg_s = DEBOUNCE_CYCLES;
  assign lvl_s        = sync2_q;
`endif

  assign edge_s       = lvl_s & ~prev_q;
  assign enter_edge_s = edge_s[0];
  assign abort_edge_s = edge_s[1];

  state_e           state_q, state_d;
  logic [WIDTH-1:0] srca_q, srca_d;
  logic [WIDTH-1:0] srcb_q, srcb_d;
  logic [2:0]       aluctl_q, aluctl_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;

  // Sequencer next state and register updates; Abort overrides Enter.
  always_comb begin
    state_d  = state_q;
    srca_d   = srca_q;
    srcb_d   = srcb_q;
    aluctl_d = aluctl_q;
    result_d = result_q;
    zero_d   = zero_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    if (abort_edge_s) begin
      state_d = GET_A;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        GET_A: begin
          if (enter_edge_s) begin
            srca_d  = Sw;
            valid_d = 1'b0;
            state_d = GET_B;
          end else begin
            state_d = GET_A;
          end
        end
        GET_B: begin
          if (enter_edge_s) begin
            srcb_d  = Sw;
            state_d = GET_OP;
          end else begin
            state_d = GET_B;
          end
        end
        GET_OP: begin
          if (enter_edge_s) begin
            aluctl_d = OpSw;
            state_d  = EXEC;
          end else begin
            state_d = GET_OP;
          end
        end
        EXEC: begin
          result_d = ALUResult;
          zero_d   = Zero;
          valid_d  = 1'b1;
          done_d   = 1'b1;
          state_d  = SHOW;
        end
        SHOW: begin
          if (enter_edge_s) begin
            state_d = GET_A;
          end else begin
            state_d = SHOW;
          end
        end
        default: begin
          state_d = GET_A;
        end
      endcase
    end
  end

  // Sequencer state and held output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= GET_A;
      srca_q   <= {WIDTH{1'b0}};
      srcb_q   <= {WIDTH{1'b0}};
      aluctl_q <= 3'b000;
      result_q <= {WIDTH{1'b0}};
      zero_q   <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      srca_q   <= srca_d;
      srcb_q   <= srcb_d;
      aluctl_q <= aluctl_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end

  assign SrcA       = srca_q;
  assign SrcB       = srcb_q;
  assign ALUControl = aluctl_q;
  assign Result     = result_q;
  assign ZeroFlag   = zero_q;
  assign Valid      = valid_q;
  assign Done       = done_q;
  assign StateOut   = state_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Testbench for alu_operand_sequencer with a small ALU stub and a
// press-level reference model of the sequencer.
`timescale 1ns/1ps
module tb_alu_operand_sequencer;

  localparam int W    = 4;
  localparam int DB   = 4;
`ifdef ALU_SEQ_DEBOUNCE_EN
  localparam int LAT  = 3 + DB;
  localparam bit DEB  = 1'b1;
`else
  localparam int LAT  = 3;
  localparam bit DEB  = 1'b0;
`endif
  localparam int HOLD = 12;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] Sw = 4'h0;
  logic [2:0]   OpSw = 3'b000;
  logic         Enter = 1'b0;
  logic         Abort = 1'b0;
  logic [W-1:0] ALUResult;
  logic         Zero;
  logic [W-1:0] SrcA, SrcB, Result;
  logic [2:0]   ALUControl, StateOut;
  logic         ZeroFlag, Valid, Done;

  int n_cmp = 0;
  int n_err = 0;
  int done_seen = 0;

  // reference model state
  int           m_state;
  logic [W-1:0] m_a, m_b, m_res;
  logic [2:0]   m_op;
  logic         m_zero, m_valid;
  int           m_done;

  alu_operand_sequencer #(.WIDTH(W), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .reset(reset), .Sw(Sw), .OpSw(OpSw), .Enter(Enter),
    .Abort(Abort), .ALUResult(ALUResult), .Zero(Zero), .SrcA(SrcA),
    .SrcB(SrcB), .ALUControl(ALUControl), .Result(Result),
    .ZeroFlag(ZeroFlag), .Valid(Valid), .Done(Done), .StateOut(StateOut)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_f(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic [2:0] op);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return (a < b) ? 4'd1 : 4'd0;
      3'd6: return ~(a | b);
      default: return a;
    endcase
  endfunction

  // ALU stub feeding the DUT
  always_comb begin
    ALUResult = alu_f(SrcA, SrcB, ALUControl);
    Zero      = (ALUResult == 4'h0);
  end

  always @(negedge clk) if (Done === 1'b1) done_seen++;

  logic [19:0] obs;
  assign obs = {SrcA, SrcB, ALUControl, Result, ZeroFlag, Valid, StateOut};

  function automatic logic [19:0] exp_vec();
    return {m_a, m_b, m_op, m_res, m_zero, m_valid, 3'(m_state)};
  endfunction

  function automatic void model_reset();
    m_state = 0; m_a = 4'h0; m_b = 4'h0; m_op = 3'b000;
    m_res = 4'h0; m_zero = 1'b0; m_valid = 1'b0;
  endfunction

  // one accepted Enter press; GET_OP runs straight through EXEC into SHOW
  function automatic void model_enter();
    case (m_state)
      0: begin m_a = Sw; m_valid = 1'b0; m_state = 1; end
      1: begin m_b = Sw; m_state = 2; end
      2: begin
        m_op = OpSw;
        m_res = alu_f(m_a, m_b, m_op);
        m_zero = (m_res == 4'h0);
        m_valid = 1'b1;
        m_done++;
        m_state = 4;
      end
      default: m_state = 0;
    endcase
  endfunction

  function automatic void model_abort();
    m_state = 0; m_valid = 1'b0;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic press(input logic en, input logic ab, input int hold);
    Enter = en; Abort = ab;
    repeat (hold) tick();
    Enter = 1'b0; Abort = 1'b0;
    repeat (HOLD) tick();
  endtask

  task automatic test_reset();
    repeat (3) tick();
    n_cmp++;
    if (obs !== 20'h0 || Done !== 1'b0) begin
      n_err++; $display("FAIL reset_state: got %h done %b, want 0 done 0", obs, Done);
    end
    reset = 1'b0;
    model_reset();
    m_done = 0;
    tick();
  endtask

  task automatic test_normal();
    int k;
    Sw = 4'h5; press(1'b1, 1'b0, HOLD); model_enter();
    Sw = 4'h3; press(1'b1, 1'b0, HOLD); model_enter();
    n_cmp++;
    if (obs !== exp_vec()) begin
      n_err++; $display("FAIL normal_load: got %h want %h", obs, exp_vec());
    end
    OpSw = 3'b001; Enter = 1'b1;
    k = 0;
    while (StateOut !== 3'd3 && k < 40) begin tick(); k++; end
    n_cmp++;
    if (StateOut !== 3'd3 || Done !== 1'b0) begin
      n_err++; $display("FAIL normal_exec: state %0d done %b, want 3 done 0", StateOut, Done);
    end
    tick();
    model_enter();
    n_cmp++;
    if (Done !== 1'b1 || obs !== exp_vec() || Result !== 4'h2) begin
      n_err++; $display("FAIL normal_show: got %h done %b, want %h done 1", obs, Done, exp_vec());
    end
    tick();
    n_cmp++;
    if (Done !== 1'b0) begin
      n_err++; $display("FAIL normal_done_pulse: done %b want 0", Done);
    end
    Enter = 1'b0;
    repeat (HOLD) tick();
  endtask

  task automatic test_zero();
    press(1'b1, 1'b0, HOLD); model_enter();            // SHOW -> GET_A
    Sw = 4'h7; press(1'b1, 1'b0, HOLD); model_enter();
    Sw = 4'h7; press(1'b1, 1'b0, HOLD); model_enter();
    OpSw = 3'b001; press(1'b1, 1'b0, HOLD); model_enter();
    n_cmp++;
    if (obs !== exp_vec() || ZeroFlag !== 1'b1) begin
      n_err++; $display("FAIL zero_flag: got %h want %h", obs, exp_vec());
    end
    press(1'b1, 1'b0, HOLD); model_enter();
    n_cmp++;
    if (obs !== exp_vec() || Valid !== 1'b1) begin
      n_err++; $display("FAIL zero_valid_held: got %h want %h", obs, exp_vec());
    end
    Sw = 4'hA; press(1'b1, 1'b0, HOLD); model_enter();
    n_cmp++;
    if (obs !== exp_vec() || Valid !== 1'b0) begin
      n_err++; $display("FAIL zero_valid_clear: got %h want %h", obs, exp_vec());
    end
  endtask

  task automatic test_latency();
    int k;
    int seen;
    logic [2:0] start;
    start = StateOut;
    seen = 0;
    Sw = 4'h6; Enter = 1'b1;
    for (k = 1; k <= LAT + 5 && seen == 0; k++) begin
      tick();
      if (StateOut !== start) seen = k;
    end
    n_cmp++;
    if (seen != LAT) begin
      n_err++; $display("FAIL latency: changed after %0d edges, want %0d", seen, LAT);
    end
    Enter = 1'b0;
    repeat (HOLD) tick();
    model_enter();
    n_cmp++;
    if (obs !== exp_vec()) begin
      n_err++; $display("FAIL latency_state: got %h want %h", obs, exp_vec());
    end
  endtask

  task automatic test_bounce();
    press(1'b0, 1'b1, HOLD); model_abort();
    Sw = 4'hC;
    Enter = 1'b1; repeat (3) tick();
    Enter = 1'b0; tick();
    Enter = 1'b1; repeat (3) tick();
    Enter = 1'b0; repeat (HOLD) tick();
    if (!DEB) begin model_enter(); model_enter(); end
    n_cmp++;
    if (obs !== exp_vec()) begin
      n_err++; $display("FAIL bounce_glitch: got %h want %h", obs, exp_vec());
    end
    Sw = 4'h9;
    press(1'b1, 1'b0, 10); model_enter();
    n_cmp++;
    if (obs !== exp_vec()) begin
      n_err++; $display("FAIL bounce_hold: got %h want %h", obs, exp_vec());
    end
  endtask

  task automatic test_abort();
    press(1'b0, 1'b1, HOLD); model_abort();
    Sw = 4'h4; press(1'b1, 1'b0, HOLD); model_enter();   // now GET_B
    Sw = 4'hE; press(1'b1, 1'b1, HOLD); model_abort();
    n_cmp++;
    if (obs !== exp_vec() || StateOut !== 3'd0) begin
      n_err++; $display("FAIL abort_priority: got %h want %h", obs, exp_vec());
    end
    Sw = 4'h8; press(1'b1, 1'b0, HOLD); model_enter();
    Sw = 4'h1; press(1'b1, 1'b0, HOLD); model_enter();
    OpSw = 3'b000; press(1'b1, 1'b0, HOLD); model_enter();
    press(1'b0, 1'b1, HOLD); model_abort();
    n_cmp++;
    if (obs !== exp_vec() || Valid !== 1'b0 || Result !== 4'h9) begin
      n_err++; $display("FAIL abort_show: got %h want %h", obs, exp_vec());
    end
  endtask

  task automatic test_async_reset();
    Sw = 4'h3; press(1'b1, 1'b0, HOLD); model_enter();
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (obs !== 20'h0 || Done !== 1'b0) begin
      n_err++; $display("FAIL async_reset: got %h want 0", obs);
    end
    #1 reset = 1'b0;
    model_reset();
    tick();
  endtask

  task automatic test_reset_exec();
    int k;
    int d0;
    Sw = 4'h9; press(1'b1, 1'b0, HOLD); model_enter();
    Sw = 4'h2; press(1'b1, 1'b0, HOLD); model_enter();
    OpSw = 3'b000; Enter = 1'b1;
    k = 0;
    while (StateOut !== 3'd3 && k < 40) begin tick(); k++; end
    n_cmp++;
    if (StateOut !== 3'd3) begin
      n_err++; $display("FAIL reset_exec_reach: state %0d want 3", StateOut);
    end
    d0 = done_seen;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (obs !== 20'h0) begin
      n_err++; $display("FAIL reset_exec_now: got %h want 0", obs);
    end
    Enter = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    model_reset();
    repeat (HOLD) tick();
    n_cmp++;
    if (done_seen != d0 || obs !== exp_vec()) begin
      n_err++; $display("FAIL reset_exec_nocapture: got %h dones %0d, want %h dones %0d",
                        obs, done_seen, exp_vec(), d0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      Sw = 4'($urandom_range(0, 15));
      OpSw = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) < 2) begin
        press(1'b0, 1'b1, HOLD); model_abort();
      end else begin
        press(1'b1, 1'b0, HOLD); model_enter();
      end
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_err++; $display("FAIL random_%0d: got %h want %h", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_done_count();
    n_cmp++;
    if (done_seen != m_done) begin
      n_err++; $display("FAIL done_count: got %0d want %0d", done_seen, m_done);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_normal();
    test_zero();
    test_latency();
    test_bounce();
    test_abort();
    test_async_reset();
    test_reset_exec();
    m_done = done_seen;
    test_random();
    test_done_count();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
